timer_cmp: RTL and testbench

//  Compare/interrupt stage paired with the 64-bit up/down counter (ctr).

---
 rtl/ctrino_timer_pkg.sv | 53 +++++
 rtl/timer_cmp_if.sv | 30 +++
 rtl/timer_prescaler.sv | 30 +++
 rtl/timer_cmp.sv | 214 +++++++++++++++++++++
 tb/tb_timer_cmp.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrino_timer_pkg.sv
// Shared types and constants for the timer compare/interrupt stage.
//   Latency: n/a (types, constants and pure helper functions only).
//   Backpressure: n/a.
// Contents: register index enum, FSM state enum, CTRL register layout,
//           compare reset value and register read-word formatting helpers.
package ctrino_timer_pkg;

  // Count/compare width and prescaler width. The compare value is split into
  // two 32-bit register halves, so the width is fixed at 64.
  localparam int TMR_WIDTH   = 64;
  localparam int TMR_PRESC_W = 8;
  localparam int REG_W       = 32;

  // Software register map.
  typedef enum logic [2:0] {
    CMP_LO = 3'd0,
    CMP_HI = 3'd1,
    CTRL   = 3'd2,
    STATUS = 3'd3,
    PER_LO = 3'd4,
    PER_HI = 3'd5
  } reg_addr_e;

  // Compare FSM. The encoding is software-visible in STATUS[2:1].
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

  // CTRL register layout: [0] EN, [1] IRQ_EN, [15:8] PRESC; other bits read 0.
  typedef struct packed {
    logic [TMR_PRESC_W-1:0] presc;
    logic [5:0]             rsvd;
    logic                   irq_en;
    logic                   en;
  } ctrl_t;

  // Compare value after reset: all-ones, so nothing fires until software
  // programs a real target.
  localparam logic [TMR_WIDTH-1:0] CMP_RESET = '1;

  // CTRL read word: the struct occupies the low 16 bits.
  function automatic logic [REG_W-1:0] ctrl_word(input ctrl_t c);
    return {16'b0, c};
  endfunction

  // STATUS read word: [0] PEND, [2:1] FSM state.
  function automatic logic [REG_W-1:0] status_word(input state_e s, input logic pend);
    return {29'b0, s, pend};
  endfunction

endpackage

// File: rtl/timer_cmp_if.sv
// Software register port of the timer compare stage.
//   Latency: read data one cycle after rd_addr; writes take effect on the strobe edge.
//   Backpressure: none; every write strobe and every read address is accepted.
// Signals: wr_en/wr_addr/wr_data (write strobe, index, data),
//          rd_addr (read index), rd_data (registered read data).
interface timer_cmp_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  // Software side (bus master / testbench).
  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  // Timer side.
  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: produces a one-cycle tick every presc+1 cycles while en is high.
//   Latency: tick is combinational from the count register and en; first tick presc+1 cycles after en rises.
//   Backpressure: none; en low clears the count and forces tick low.
// Ports: clk, reset (sync, active-high), en (run), presc (period-1), tick (enable pulse).
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] presc,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  // Gating with en keeps tick low on the cycle EN drops, before cnt clears.
  assign tick = en && (cnt_q == presc);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_cmp.sv
// Timer compare/interrupt stage: prescaled tick to the counter, 64-bit compare, level irq.
//   Latency: irq_o one cycle after the matching count_i; rd_data one cycle after rd_addr.
//   Backpressure: none; register writes and acks are always accepted.
// Ports: clk, reset (sync, active-high); count_i (counter value); tick_o (counter enable pulse);
//        bus (register write/read port, slave side); irq_o (level interrupt); irq_ack_i (ack pulse).
// Build option: TIMER_PERIODIC_EN adds the period register (PER_LO/PER_HI) and auto-reload.
module timer_cmp
  import ctrino_timer_pkg::*;
#(
  parameter int WIDTH   = TMR_WIDTH,
  parameter int PRESC_W = TMR_PRESC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_i,
  output logic             tick_o,
  timer_cmp_if.slave       bus,
  output logic             irq_o,
  input  logic             irq_ack_i
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] cmp_q,  cmp_d;
  logic [REG_W-1:0] lo_q,   lo_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             pend_q, pend_d;
  logic             irq_q;
  logic [REG_W-1:0] rd_q,   rd_d;
  state_e           state_q, state_d;

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic lo_wr, commit, ctrl_wr, stat_wr;

  assign lo_wr   = bus.wr_en && (bus.wr_addr == CMP_LO);
  assign commit  = bus.wr_en && (bus.wr_addr == CMP_HI);
  assign ctrl_wr = bus.wr_en && (bus.wr_addr == CTRL);
  assign stat_wr = bus.wr_en && (bus.wr_addr == STATUS);

  // ---------------------------------------------------------------------
  // Compare. Only ARMED compares, so a count that wraps or counts back
  // down past cmp while FIRED cannot raise a second event.
  // ---------------------------------------------------------------------
  logic fire;
  logic reload;

  assign fire = (state_q == ARMED) && (count_i >= cmp_q);

`ifdef TIMER_PERIODIC_EN
  // Period register: PER_LO stages, PER_HI commits both halves together.
  logic [REG_W-1:0] per_lo_q;
  logic [WIDTH-1:0] period_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      per_lo_q <= '0;
      period_q <= '0;
    end else if (bus.wr_en && (bus.wr_addr == PER_LO)) begin
      per_lo_q <= bus.wr_data;
    end else if (bus.wr_en && (bus.wr_addr == PER_HI)) begin
      period_q <= {bus.wr_data, per_lo_q};
    end
  end

  // A zero period degenerates to one-shot behaviour.
  assign reload = fire && (period_q != '0);
`else
  assign reload = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------
  always_comb begin
    lo_d   = lo_q;
    cmp_d  = cmp_q;
    ctrl_d = ctrl_q;
    pend_d = pend_q;

    if (lo_wr) begin
      lo_d = bus.wr_data;
    end

    // A software commit overrides an auto-reload in the same cycle: the
    // freshly written target is what software expects to be armed.
    if (commit) begin
      cmp_d = {bus.wr_data, lo_q};
    end
`ifdef TIMER_PERIODIC_EN
    else if (reload) begin
      cmp_d = cmp_q + period_q;
    end
`endif

    if (ctrl_wr) begin
      ctrl_d.presc  = bus.wr_data[8 +: TMR_PRESC_W];
      ctrl_d.rsvd   = '0;
      ctrl_d.irq_en = bus.wr_data[1];
      ctrl_d.en     = bus.wr_data[0];
    end

    // Clear first, then fire, so a fire coinciding with a clear is not lost.
    if (irq_ack_i || (stat_wr && bus.wr_data[0])) begin
      pend_d = 1'b0;
    end
    if (fire) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q   <= '0;
      cmp_q  <= CMP_RESET;
      ctrl_q <= '0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      cmp_q  <= cmp_d;
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      // Built from next-state values so irq_o lines up with PEND.
      irq_q  <= pend_d && ctrl_d.irq_en;
    end
  end

  assign irq_o = irq_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_wr && !bus.wr_data[0]) begin
      // Disabling always parks the FSM; PEND is left for software.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if ((commit && ctrl_q.en) || (ctrl_wr && bus.wr_data[0] && !ctrl_q.en)) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          // Reload or a fresh commit keeps the compare live.
          if (fire && !reload && !commit) begin
            state_d = FIRED;
          end
        end
        FIRED: begin
          if (commit) begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read port: sampled from current register values, so a same-cycle write
  // to the read address shows up one read later.
  // ---------------------------------------------------------------------
  always_comb begin
    rd_d = '0;
    case (bus.rd_addr)
      CMP_LO:  rd_d = cmp_q[REG_W-1:0];
      CMP_HI:  rd_d = cmp_q[WIDTH-1:REG_W];
      CTRL:    rd_d = ctrl_word(ctrl_q);
      STATUS:  rd_d = status_word(state_q, pend_q);
`ifdef TIMER_PERIODIC_EN
      PER_LO:  rd_d = period_q[REG_W-1:0];
      PER_HI:  rd_d = period_q[WIDTH-1:REG_W];
`endif
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.rd_data = rd_q;

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  timer_prescaler #(
    .W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .presc (ctrl_q.presc),
    .tick  (tick_o)
  );

endmodule

// File: tb/tb_timer_cmp.sv
// Directed bench for timer_cmp: register reads go through an expected-value
// queue that is filled when the read is issued and drained when rd_data is due.
module tb_timer_cmp;
  import ctrino_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] count;
  logic        tick;
  logic        irq;
  logic        irq_ack;

  timer_cmp_if bus();

  timer_cmp dut (
    .clk       (clk),
    .reset     (reset),
    .count_i   (count),
    .tick_o    (tick),
    .bus       (bus),
    .irq_o     (irq),
    .irq_ack_i (irq_ack)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          rd_pending = 1'b0;

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs settle after the edge, strobes drop, due read is scored.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    irq_ack   = 1'b0;
    if (rd_pending) begin
      rd_pending = 1'b0;
      if (exp_q.size() == 0) begin
        chk(64'(bus.rd_data), 64'hDEAD, "scoreboard_empty");
      end else begin
        chk(64'(bus.rd_data), 64'(exp_q.pop_front()), tag_q.pop_front());
      end
    end
  endtask

  task automatic wr_issue(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic rd_issue(input logic [2:0] a, input logic [31:0] expv, input string tag);
    bus.rd_addr = a;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    rd_pending = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_issue(a, d);
    cyc();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] expv, input string tag);
    rd_issue(a, expv, tag);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] cmpv;
    reset       = 1'b1;
    count       = '0;
    irq_ack     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    cyc();
    cyc();

    // Reset state
    chk(64'(tick), 64'd0, "rst_tick");
    chk(64'(irq), 64'd0, "rst_irq");
    chk(64'(bus.rd_data), 64'd0, "rst_rd_data");
    reset = 1'b0;
    rd(CMP_LO, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(CMP_HI, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(CTRL,   32'h0, "rst_ctrl");
    rd(STATUS, 32'h0, "rst_status");
    rd(3'd6,   32'h0, "unmapped_rd");

    // Prescaler: PRESC=3 ticks every 4th cycle
    wr(CTRL, 32'h0000_0301);
    rd(CTRL, 32'h0000_0301, "ctrl_rb");
    // The read cycle advanced the prescaler by one; realign to cnt=0.
    for (int i = 1; i < 4; i++) begin
      chk(64'(tick), 64'(i % 4 == 3), "t1_tick_align");
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      chk(64'(tick), 64'(i % 4 == 3), "t1_tick");
      cyc();
    end
    cyc();
    cyc();
    wr(CTRL, 32'h0000_0300);          // EN=0 mid-count
    for (int i = 0; i < 6; i++) begin
      chk(64'(tick), 64'd0, "t1_tick_off");
      cyc();
    end
    wr(CTRL, 32'h0000_0301);          // re-enable
    for (int i = 0; i < 4; i++) begin
      chk(64'(tick), 64'(i == 3), "t1_tick_reen");
      cyc();
    end
    wr(CTRL, 32'h0);
    wr(CTRL, 32'h0000_0001);          // PRESC=0: tick every cycle
    for (int i = 0; i < 3; i++) begin
      chk(64'(tick), 64'd1, "t1_presc0");
      cyc();
    end
    wr(CTRL, 32'h0);

    // Compare match on a ramping count
    cmpv = 64'h0000_0001_0000_0010;
    wr(CMP_LO, 32'h0000_0010);
    wr(CMP_HI, 32'h0000_0001);        // committed while EN=0: stays IDLE
    rd(STATUS, 32'h0, "t2_idle");
    wr(CTRL, 32'h0000_0003);          // EN 0->1 arms
    rd(STATUS, 32'h2, "t2_armed");
    for (int k = 0; k < 6; k++) begin
      count = 64'h0000_0001_0000_000D + 64'(k);
      cyc();
      chk(64'(irq), 64'(count >= cmpv), "t2_irq");
    end
    rd(STATUS, 32'h5, "t2_status_fired");
    rd(CMP_LO, 32'h0000_0010, "t2_cmp_lo");
    rd(CMP_HI, 32'h0000_0001, "t2_cmp_hi");
    irq_ack = 1'b1;
    cyc();
    chk(64'(irq), 64'd0, "t2_ack");
    count = '1;
    cyc();
    count = '0;                       // wrap while FIRED
    cyc();
    chk(64'(irq), 64'd0, "t2_wrap_no_refire");
    rd(STATUS, 32'h4, "t2_fired_nopend");

    // Staged low half alone does not commit
    wr(CTRL, 32'h0);
    count = 64'd9;
    wr(CMP_LO, 32'h5);
    rd(STATUS, 32'h0, "t3_no_arm");
    rd(CMP_LO, 32'h0000_0010, "t3_no_commit");
    wr(CTRL, 32'h0000_0003);
    chk(64'(irq), 64'd0, "t3_armed_quiet");
    wr(CMP_HI, 32'h0);                // cmp=5, already below count
    chk(64'(irq), 64'd0, "t3_commit_edge");
    cyc();
    chk(64'(irq), 64'd1, "t3_late_fire");
    rd(STATUS, 32'h5, "t3_status");
    rd(CMP_LO, 32'h5, "t3_cmp_lo");
    rd(CMP_HI, 32'h0, "t3_cmp_hi");
    wr_issue(STATUS, 32'h1);          // W1C with same-cycle read: old value
    rd_issue(STATUS, 32'h5, "t3_rw_old");
    cyc();
    chk(64'(irq), 64'd0, "t3_w1c_irq");
    rd(STATUS, 32'h4, "t3_w1c_status");

    // Fire coinciding with ack: PEND stays set
    count = 64'd0;
    wr(CMP_LO, 32'h20);
    wr(CMP_HI, 32'h0);
    rd(STATUS, 32'h2, "t4_rearmed");
    count   = 64'h20;
    irq_ack = 1'b1;
    cyc();
    chk(64'(irq), 64'd1, "t4_fire_beats_ack");
    rd(STATUS, 32'h5, "t4_status");
    irq_ack = 1'b1;
    cyc();
    chk(64'(irq), 64'd0, "t4_ack_alone");

    // IRQ_EN masks the output but not PEND
    wr(CTRL, 32'h0000_0001);
    wr(CMP_LO, 32'h30);
    wr(CMP_HI, 32'h0);
    count = 64'h30;
    cyc();
    chk(64'(irq), 64'd0, "t4_masked");
    rd(STATUS, 32'h5, "t4_masked_pend");
    wr(CTRL, 32'h0000_0003);
    chk(64'(irq), 64'd1, "t4_unmask");

    // Reset while FIRED with irq high
    reset = 1'b1;
    cyc();
    chk(64'(irq), 64'd0, "t6_irq");
    chk(64'(tick), 64'd0, "t6_tick");
    chk(64'(bus.rd_data), 64'd0, "t6_rd_data");
    reset = 1'b0;
    rd(CTRL,   32'h0, "t6_ctrl");
    rd(CMP_LO, 32'hFFFF_FFFF, "t6_cmp_lo");
    rd(CMP_HI, 32'hFFFF_FFFF, "t6_cmp_hi");
    rd(STATUS, 32'h0, "t6_status");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(CTRL, 32'h0, "unmapped_wr_ignored");

    // Period register
    count = '0;
    wr(PER_LO, 32'd10);
    wr(PER_HI, 32'd0);
`ifdef TIMER_PERIODIC_EN
    rd(PER_LO, 32'd10, "t5_per_lo");
    rd(PER_HI, 32'd0, "t5_per_hi");
    wr(CMP_LO, 32'd10);
    wr(CMP_HI, 32'd0);
    wr(CTRL, 32'h0000_0003);
    for (int c = 0; c < 34; c++) begin
      count   = 64'(c);
      irq_ack = (c == 11) || (c == 21) || (c == 31);
      cyc();
      chk(64'(irq), 64'((c == 10) || (c == 20) || (c == 30)), "t5_irq");
    end
    rd(CMP_LO, 32'd40, "t5_cmp_after3");
    rd(STATUS, 32'h2, "t5_still_armed");
`else
    rd(PER_LO, 32'h0, "per_lo_absent");
    rd(PER_HI, 32'h0, "per_hi_absent");
`endif

    chk(64'(rd_pending), 64'd0, "read_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
